dram_arbiter: RTL and testbench

Shares the single-port data RAM between the single-cycle core's load/store port and a debug/loader port, so memory can be inspected or preloaded while the core runs. CPU accesses win by default and are granted in the same cycle. A saturating starvation counter guarantees debug progress, and a bounded lock mode lets the debug side perform uninterrupted bursts. The block sits between the core's memory stage and the data RAM; when it is instantiated, the core's PC register must honour `o_CpuStall_1`.

---
 rtl/dram_arb_pkg.sv | 17 +
 rtl/arb_sat_counter.sv | 40 ++++
 rtl/dram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dram_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg
//   Shared types and constants for the data-RAM arbiter: arbitration state
//   enum, default address/data widths and the widths of the starvation and
//   lock counters.
package dram_arb_pkg;

  typedef enum logic {
    S_SHARED = 1'b0,  // CPU has priority, debug wins only when starved
    S_LOCK   = 1'b1   // debug owns the bus for a bounded burst
  } arbState_t;

  localparam int unsigned DEF_ADDR_W   = 12;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned STARVE_CNT_W = 4;
  localparam int unsigned LOCK_CNT_W   = 8;

endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter
//   Saturating up-counter with clear, load and increment controls.
//   Priority: clr > load > inc. Increment stops at MAX.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   inc        - count up by one (saturating at MAX)
//   clr        - synchronous clear to zero
//   load       - synchronous load of loadVal
//   loadVal    - value used by load
//   count      - current count
module arb_sat_counter
  import dram_arb_pkg::*;
#(
  parameter int unsigned WIDTH = STARVE_CNT_W,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (inc && (count != TOP)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares a single-port data RAM between the core's load/store port (CPU,
//   zero-latency, default priority) and a debug/loader port. A saturating
//   starvation counter forces a debug grant after STARVE_MAX denied cycles;
//   a bounded lock mode lets debug run uninterrupted bursts of up to
//   LOCK_MAX locked cycles.
// Ports:
//   clk, rstn              - clock, asynchronous active-low reset
//   i_Cpu* / o_Cpu*        - core request, grant, stall, combinational read data
//   i_Dbg* / o_Dbg*        - debug request/lock, grant, registered read data
//   o_Ram* / i_RamRdata    - RAM address/write port, asynchronous read data
//   o_StallCnt, o_DbgGntCnt- statistics counters
// Configuration:
//   DRAM_ARB_STATS_EN - when defined, o_StallCnt counts CPU stall cycles and
//   o_DbgGntCnt counts debug grants; otherwise both are tied to zero.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LOCK_MAX   = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_CpuReq_1,
  input  logic              i_CpuWe_1,
  input  logic [ADDR_W-1:0] i_CpuAddr,
  input  logic [DATA_W-1:0] i_CpuWdata,
  output logic              o_CpuGnt_1,
  output logic              o_CpuStall_1,
  output logic [DATA_W-1:0] o_CpuRdata,
  input  logic              i_DbgReq_1,
  input  logic              i_DbgWe_1,
  input  logic              i_DbgLock_1,
  input  logic [ADDR_W-1:0] i_DbgAddr,
  input  logic [DATA_W-1:0] i_DbgWdata,
  output logic              o_DbgGnt_1,
  output logic              o_DbgRvalid_1,
  output logic [DATA_W-1:0] o_DbgRdata,
  output logic [ADDR_W-1:0] o_RamAddr,
  output logic [DATA_W-1:0] o_RamWdata,
  output logic              o_RamWe_1,
  input  logic [DATA_W-1:0] i_RamRdata,
  output logic [31:0]       o_StallCnt,
  output logic [31:0]       o_DbgGntCnt
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_TOP = STARVE_CNT_W'(STARVE_MAX);
  localparam logic [LOCK_CNT_W-1:0]   LOCK_TOP   = LOCK_CNT_W'(LOCK_MAX);

  arbState_t               state, stateNext;
  logic [STARVE_CNT_W-1:0] starveCnt;
  logic [LOCK_CNT_W-1:0]   lockCnt;
  logic                    starveFull, lockFull;
  logic                    cpuGnt, dbgGnt;
  logic                    enterLock, leaveLock, forcedExit;

  assign starveFull = (starveCnt == STARVE_TOP);
  assign lockFull   = (lockCnt == LOCK_TOP);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_SHARED;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      S_SHARED: if (dbgGnt && i_DbgLock_1)        stateNext = S_LOCK;
      S_LOCK:   if (!i_DbgLock_1 || lockFull)     stateNext = S_SHARED;
      default:                                    stateNext = S_SHARED;
    endcase
  end

  // Grant logic; gated by rstn so nothing reaches the RAM while in reset
  always_comb begin
    cpuGnt = 1'b0;
    dbgGnt = 1'b0;
    if (rstn) begin
      case (state)
        S_SHARED: begin
          dbgGnt = i_DbgReq_1 && (!i_CpuReq_1 || starveFull);
          cpuGnt = i_CpuReq_1 && !dbgGnt;
        end
        S_LOCK:  dbgGnt = i_DbgReq_1;
        default: ;
      endcase
    end
  end

  assign o_CpuGnt_1   = cpuGnt;
  assign o_DbgGnt_1   = dbgGnt;
  assign o_CpuStall_1 = i_CpuReq_1 & ~cpuGnt;
  assign o_CpuRdata   = i_RamRdata;

  // RAM port mux: idle cycles keep the CPU address so reads stay zero-latency
  always_comb begin
    o_RamAddr  = i_CpuAddr;
    o_RamWdata = i_CpuWdata;
    o_RamWe_1  = 1'b0;
    if (dbgGnt) begin
      o_RamAddr  = i_DbgAddr;
      o_RamWdata = i_DbgWdata;
      o_RamWe_1  = i_DbgWe_1;
    end else if (cpuGnt) begin
      o_RamWe_1  = i_CpuWe_1;
    end
  end

  assign enterLock  = (state == S_SHARED) && (stateNext == S_LOCK);
  assign leaveLock  = (state == S_LOCK) && (stateNext == S_SHARED);
  // Hitting the lock limit clears starvation so the CPU gets the next cycle
  assign forcedExit = (state == S_LOCK) && lockFull;

  arb_sat_counter #(
    .WIDTH (STARVE_CNT_W),
    .MAX   (STARVE_MAX)
  ) u_starveCnt (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (i_DbgReq_1 && !dbgGnt),
    .clr     (dbgGnt || forcedExit),
    .load    (1'b0),
    .loadVal ('0),
    .count   (starveCnt)
  );

  arb_sat_counter #(
    .WIDTH (LOCK_CNT_W),
    .MAX   (LOCK_MAX)
  ) u_lockCnt (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (state == S_LOCK),
    .clr     (leaveLock),
    .load    (enterLock),
    .loadVal (LOCK_CNT_W'(1)),
    .count   (lockCnt)
  );

  // Debug read return path
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_DbgRvalid_1 <= 1'b0;
      o_DbgRdata    <= '0;
    end else begin
      o_DbgRvalid_1 <= dbgGnt && !i_DbgWe_1;
      if (dbgGnt && !i_DbgWe_1) o_DbgRdata <= i_RamRdata;
    end
  end

`ifdef DRAM_ARB_STATS_EN
  logic [31:0] stallCnt, dbgGntCnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stallCnt  <= '0;
      dbgGntCnt <= '0;
    end else begin
      if (o_CpuStall_1) stallCnt  <= stallCnt + 32'd1;
      if (dbgGnt)       dbgGntCnt <= dbgGntCnt + 32'd1;
    end
  end

  assign o_StallCnt  = stallCnt;
  assign o_DbgGntCnt = dbgGntCnt;
`else
  assign o_StallCnt  = '0;
  assign o_DbgGntCnt = '0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
//   Self-checking bench for dram_arbiter with STARVE_MAX=4, LOCK_MAX=8.
//   A behavioural reference (lock flag, wait/age counts, reference memory)
//   predicts every cycle; the RAM itself is a bench-side array.
module tb_dram_arbiter;

  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;
  localparam int unsigned LMAX = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cpuReq, cpuWe, dbgReq, dbgWe, dbgLock;
  logic [AW-1:0] cpuAddr, dbgAddr;
  logic [DW-1:0] cpuWdata, dbgWdata;
  logic          cpuGnt, cpuStall, dbgGnt, dbgRvalid, ramWe;
  logic [DW-1:0] cpuRdata, dbgRdata, ramWdata, ramRdata;
  logic [AW-1:0] ramAddr;
  logic [31:0]   stallCnt, dbgGntCnt;

  logic [DW-1:0] ram    [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] refMem [0:(1<<AW)-1] = '{default: '0};

  int checks = 0;
  int failures = 0;

  bit            mLocked;
  int            mWait, mAge, mStall, mGnt;
  bit            mRvalid;
  logic [DW-1:0] mRdata;

  always #5 clk = ~clk;

  assign ramRdata = ram[ramAddr];
  always @(posedge clk) if (ramWe) ram[ramAddr] <= ramWdata;

  dram_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX),
    .LOCK_MAX   (LMAX)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_CpuReq_1    (cpuReq),
    .i_CpuWe_1     (cpuWe),
    .i_CpuAddr     (cpuAddr),
    .i_CpuWdata    (cpuWdata),
    .o_CpuGnt_1    (cpuGnt),
    .o_CpuStall_1  (cpuStall),
    .o_CpuRdata    (cpuRdata),
    .i_DbgReq_1    (dbgReq),
    .i_DbgWe_1     (dbgWe),
    .i_DbgLock_1   (dbgLock),
    .i_DbgAddr     (dbgAddr),
    .i_DbgWdata    (dbgWdata),
    .o_DbgGnt_1    (dbgGnt),
    .o_DbgRvalid_1 (dbgRvalid),
    .o_DbgRdata    (dbgRdata),
    .o_RamAddr     (ramAddr),
    .o_RamWdata    (ramWdata),
    .o_RamWe_1     (ramWe),
    .i_RamRdata    (ramRdata),
    .o_StallCnt    (stallCnt),
    .o_DbgGntCnt   (dbgGntCnt)
  );

  task automatic setIdle;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
    dbgReq = 1'b0; dbgWe = 1'b0; dbgLock = 1'b0; dbgAddr = '0; dbgWdata = '0;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset;
    mLocked = 1'b0; mWait = 0; mAge = 0; mRvalid = 1'b0; mRdata = '0;
    mStall = 0; mGnt = 0;
  endtask

  task automatic predict(output bit eCpu, output bit eDbg);
    eCpu = 1'b0;
    eDbg = 1'b0;
    if (rstn === 1'b1) begin
      if (mLocked) begin
        eDbg = (dbgReq === 1'b1);
      end else begin
        eDbg = (dbgReq === 1'b1) && (cpuReq !== 1'b1 || mWait >= int'(SMAX));
        eCpu = (cpuReq === 1'b1) && !eDbg;
      end
    end
  endtask

  task automatic advance(input bit eCpu, input bit eDbg);
    if (cpuReq && !eCpu) mStall++;
    if (eDbg) begin
      mGnt++;
      mWait = 0;
      mRvalid = !dbgWe;
      if (!dbgWe) mRdata = refMem[dbgAddr];
      else        refMem[dbgAddr] = dbgWdata;
    end else begin
      mRvalid = 1'b0;
      if (dbgReq && mWait < int'(SMAX)) mWait++;
    end
    if (eCpu && cpuWe) refMem[cpuAddr] = cpuWdata;
    if (!mLocked) begin
      if (eDbg && dbgLock) begin
        mLocked = 1'b1;
        mAge = 1;
      end
    end else if (!dbgLock || mAge == int'(LMAX)) begin
      if (mAge == int'(LMAX)) mWait = 0;
      mLocked = 1'b0;
    end else begin
      mAge++;
    end
  endtask

  task automatic test_reset;
    setIdle();
    cpuReq = 1'b1; cpuWe = 1'b1; dbgReq = 1'b1; dbgWe = 1'b1;
    modelReset();
    @(negedge clk);
    checks++;
    if ({cpuGnt, dbgGnt, ramWe} !== 3'b000) begin
      failures++;
      $display("FAIL reset_grants got cpuGnt=%b dbgGnt=%b ramWe=%b want 000", cpuGnt, dbgGnt, ramWe);
    end
    checks++;
    if (dbgRvalid !== 1'b0 || dbgRdata !== '0 || stallCnt !== '0 || dbgGntCnt !== '0) begin
      failures++;
      $display("FAIL reset_regs got rvalid=%b rdata=%h stall=%0d gnt=%0d want all 0",
               dbgRvalid, dbgRdata, stallCnt, dbgGntCnt);
    end
    setIdle();
    @(negedge clk);
    rstn = 1'b1;
    nextCycle();
  endtask

  task automatic test_cpu_only;
    bit eC, eD;
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 12'h010; cpuWdata = 32'hDEADBEEF;
    @(negedge clk);
    predict(eC, eD);
    checks++;
    if (cpuGnt !== 1'b1 || cpuStall !== 1'b0 || ramWe !== 1'b1 || ramAddr !== 12'h010) begin
      failures++;
      $display("FAIL cpu_write got gnt=%b stall=%b we=%b addr=%h want 1 0 1 010",
               cpuGnt, cpuStall, ramWe, ramAddr);
    end
    advance(eC, eD);
    nextCycle();
    cpuAddr = 12'h020; cpuWdata = 32'h5A5A0020;
    @(negedge clk);
    predict(eC, eD);
    advance(eC, eD);
    nextCycle();
    cpuWe = 1'b0; cpuAddr = 12'h010;
    @(negedge clk);
    predict(eC, eD);
    checks++;
    if (cpuGnt !== 1'b1 || cpuStall !== 1'b0 || cpuRdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL cpu_read got gnt=%b stall=%b rdata=%h want 1 0 deadbeef",
               cpuGnt, cpuStall, cpuRdata);
    end
    advance(eC, eD);
    nextCycle();
    setIdle();
  endtask

  task automatic test_starve;
    bit eC, eD;
    int grantAt = -1;
    int stalls = 0;
    dbgReq = 1'b1; dbgWe = 1'b0; dbgLock = 1'b0; dbgAddr = 12'h020;
    cpuReq = 1'b1; cpuWe = 1'b0;
    for (int i = 0; i < 10 && grantAt < 0; i++) begin
      cpuAddr = AW'($urandom_range(0, 255));
      @(negedge clk);
      predict(eC, eD);
      checks++;
      if (dbgGnt !== eD || cpuGnt !== eC) begin
        failures++;
        $display("FAIL starve_grant cyc=%0d got cpu=%b dbg=%b want cpu=%b dbg=%b",
                 i, cpuGnt, dbgGnt, eC, eD);
      end
      if (cpuStall === 1'b1) stalls++;
      if (dbgGnt === 1'b1) grantAt = i;
      advance(eC, eD);
      nextCycle();
    end
    checks++;
    if (grantAt != int'(SMAX) || stalls != 1) begin
      failures++;
      $display("FAIL starve_wait got grantCycle=%0d stalls=%0d want %0d 1", grantAt, stalls, SMAX);
    end
    dbgReq = 1'b0;
    @(negedge clk);
    predict(eC, eD);
    checks++;
    if (dbgRvalid !== 1'b1 || dbgRdata !== 32'h5A5A0020) begin
      failures++;
      $display("FAIL starve_rvalid got rvalid=%b rdata=%h want 1 5a5a0020", dbgRvalid, dbgRdata);
    end
    advance(eC, eD);
    nextCycle();
    setIdle();
  endtask

  task automatic test_dbg_write_idle;
    bit eC, eD;
    dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 12'h030; dbgWdata = 32'h12345678;
    @(negedge clk);
    predict(eC, eD);
    checks++;
    if (dbgGnt !== 1'b1 || ramWe !== 1'b1 || ramAddr !== 12'h030 || ramWdata !== 32'h12345678) begin
      failures++;
      $display("FAIL dbg_write got gnt=%b we=%b addr=%h wdata=%h want 1 1 030 12345678",
               dbgGnt, ramWe, ramAddr, ramWdata);
    end
    advance(eC, eD);
    nextCycle();
    setIdle();
    cpuReq = 1'b1; cpuAddr = 12'h030;
    @(negedge clk);
    predict(eC, eD);
    checks++;
    if (cpuRdata !== 32'h12345678 || dbgRvalid !== 1'b0) begin
      failures++;
      $display("FAIL dbg_write_readback got rdata=%h rvalid=%b want 12345678 0", cpuRdata, dbgRvalid);
    end
    advance(eC, eD);
    nextCycle();
    setIdle();
  endtask

  task automatic test_lock_burst;
    bit eC, eD;
    int k = 0;
    int stalls = 0;
    cpuReq = 1'b1; cpuWe = 1'b0;
    for (int cyc = 0; cyc < 30 && k < 3; cyc++) begin
      dbgReq = 1'b1; dbgWe = 1'b1; dbgLock = (k < 2);
      dbgAddr = AW'(32'h40 + k); dbgWdata = 32'hA0000000 + DW'(k);
      cpuAddr = AW'($urandom_range(0, 255));
      @(negedge clk);
      predict(eC, eD);
      checks++;
      if (dbgGnt !== eD || cpuGnt !== eC) begin
        failures++;
        $display("FAIL lock_burst_grant k=%0d got cpu=%b dbg=%b want cpu=%b dbg=%b",
                 k, cpuGnt, dbgGnt, eC, eD);
      end
      if (dbgGnt === 1'b1) k++;
      if (k > 0 && cpuStall === 1'b1) stalls++;
      advance(eC, eD);
      nextCycle();
    end
    dbgReq = 1'b0; dbgLock = 1'b0;
    @(negedge clk);
    predict(eC, eD);
    checks++;
    if (k != 3 || stalls != 3 || cpuGnt !== 1'b1) begin
      failures++;
      $display("FAIL lock_burst got writes=%0d stalls=%0d cpuGntAfter=%b want 3 3 1", k, stalls, cpuGnt);
    end
    advance(eC, eD);
    nextCycle();
    for (int j = 0; j < 3; j++) begin
      cpuAddr = AW'(32'h40 + j);
      @(negedge clk);
      predict(eC, eD);
      checks++;
      if (cpuRdata !== 32'hA0000000 + DW'(j)) begin
        failures++;
        $display("FAIL lock_burst_data addr=%h got %h want %h", cpuAddr, cpuRdata, 32'hA0000000 + DW'(j));
      end
      advance(eC, eD);
      nextCycle();
    end
    setIdle();
  endtask

  task automatic test_lock_max;
    bit eC, eD;
    int run = 0;
    bit done = 1'b0;
    bit cpuAfter = 1'b0, dbgAfter = 1'b1;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 12'h011;
    dbgReq = 1'b1; dbgWe = 1'b0; dbgLock = 1'b1; dbgAddr = 12'h050;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      predict(eC, eD);
      checks++;
      if (dbgGnt !== eD || cpuGnt !== eC) begin
        failures++;
        $display("FAIL lock_max_grant cyc=%0d got cpu=%b dbg=%b want cpu=%b dbg=%b",
                 cyc, cpuGnt, dbgGnt, eC, eD);
      end
      if (dbgGnt === 1'b1) begin
        run++;
      end else if (run > 0) begin
        done = 1'b1;
        cpuAfter = cpuGnt;
        dbgAfter = dbgGnt;
      end
      advance(eC, eD);
      nextCycle();
    end
    checks++;
    if (run != int'(LMAX) + 1 || cpuAfter !== 1'b1 || dbgAfter !== 1'b0) begin
      failures++;
      $display("FAIL lock_max got dbgRun=%0d cpuAfter=%b dbgAfter=%b want %0d 1 0",
               run, cpuAfter, dbgAfter, LMAX + 1);
    end
    setIdle();
  endtask

  task automatic test_reset_mid_lock;
    bit eC, eD;
    int cyc = 0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 12'h012;
    dbgReq = 1'b1; dbgWe = 1'b0; dbgLock = 1'b1; dbgAddr = 12'h060;
    while (!mLocked && cyc < 20) begin
      @(negedge clk);
      predict(eC, eD);
      advance(eC, eD);
      nextCycle();
      cyc++;
    end
    @(negedge clk);
    predict(eC, eD);
    checks++;
    if (dbgGnt !== 1'b1 || cpuGnt !== 1'b0 || dbgRvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_lock_pre got dbg=%b cpu=%b rvalid=%b want 1 0 1", dbgGnt, cpuGnt, dbgRvalid);
    end
    #1 rstn = 1'b0;
    modelReset();
    #1;
    checks++;
    if (dbgGnt !== 1'b0 || cpuGnt !== 1'b0 || ramWe !== 1'b0 || dbgRvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_lock_reset got dbg=%b cpu=%b we=%b rvalid=%b want 0 0 0 0",
               dbgGnt, cpuGnt, ramWe, dbgRvalid);
    end
    nextCycle();
    checks++;
    if (dbgRvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_lock_rvalid got %b want 0", dbgRvalid);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    predict(eC, eD);
    checks++;
    if (cpuGnt !== 1'b1 || dbgGnt !== 1'b0 || stallCnt !== '0 || dbgGntCnt !== '0) begin
      failures++;
      $display("FAIL mid_lock_release got cpu=%b dbg=%b stall=%0d gnt=%0d want 1 0 0 0",
               cpuGnt, dbgGnt, stallCnt, dbgGntCnt);
    end
    advance(eC, eD);
    nextCycle();
    setIdle();
  endtask

  task automatic test_random;
    bit eC, eD;
    bit cpuPend = 1'b0, dbgPend = 1'b0;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    logic          expWe;
    logic [31:0]   expStall, expGntCnt;
    for (int i = 0; i < 400; i++) begin
      if (!cpuPend) begin
        cpuReq = ($urandom_range(0, 3) != 0);
        cpuWe = $urandom_range(0, 1) == 1;
        cpuAddr = AW'($urandom_range(0, 15));
        cpuWdata = $urandom;
      end
      if (!dbgPend) begin
        dbgReq = ($urandom_range(0, 2) == 0);
        dbgWe = $urandom_range(0, 1) == 1;
        dbgLock = ($urandom_range(0, 3) == 0);
        dbgAddr = AW'($urandom_range(0, 15));
        dbgWdata = $urandom;
      end
      @(negedge clk);
      predict(eC, eD);
      expAddr  = eD ? dbgAddr : cpuAddr;
      expWdata = eD ? dbgWdata : cpuWdata;
      expWe    = eD ? dbgWe : (eC ? cpuWe : 1'b0);
`ifdef DRAM_ARB_STATS_EN
      expStall  = 32'(mStall);
      expGntCnt = 32'(mGnt);
`else
      expStall  = '0;
      expGntCnt = '0;
`endif
      checks++;
      if ({cpuGnt, dbgGnt, cpuStall, ramWe} !== {eC, eD, cpuReq & ~eC, expWe}) begin
        failures++;
        $display("FAIL rnd_ctrl cyc=%0d got gnt/dgnt/stall/we=%b%b%b%b want %b%b%b%b",
                 i, cpuGnt, dbgGnt, cpuStall, ramWe, eC, eD, cpuReq & ~eC, expWe);
      end
      checks++;
      if (ramAddr !== expAddr || (expWe && ramWdata !== expWdata) || cpuRdata !== refMem[expAddr]) begin
        failures++;
        $display("FAIL rnd_ram cyc=%0d got addr=%h wdata=%h rdata=%h want %h %h %h",
                 i, ramAddr, ramWdata, cpuRdata, expAddr, expWdata, refMem[expAddr]);
      end
      checks++;
      if (dbgRvalid !== mRvalid || dbgRdata !== mRdata) begin
        failures++;
        $display("FAIL rnd_dbgread cyc=%0d got rvalid=%b rdata=%h want %b %h",
                 i, dbgRvalid, dbgRdata, mRvalid, mRdata);
      end
      checks++;
      if (stallCnt !== expStall || dbgGntCnt !== expGntCnt) begin
        failures++;
        $display("FAIL rnd_stats cyc=%0d got stall=%0d gnt=%0d want %0d %0d",
                 i, stallCnt, dbgGntCnt, expStall, expGntCnt);
      end
      cpuPend = cpuReq && !eC;
      dbgPend = dbgReq && !eD;
      advance(eC, eD);
      nextCycle();
    end
    setIdle();
  endtask

  initial begin
    setIdle();
    test_reset();
    test_cpu_only();
    test_starve();
    test_dbg_write_idle();
    test_lock_burst();
    test_lock_max();
    test_reset_mid_lock();
    test_random();
    repeat (2) nextCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
